taylor_frame_ctrl: RTL and testbench

- Frame sequencer between a streaming sample source/sink and one proc_fl float-processor instance (after int2float/float2int and the addr_dec decoders).
- Per frame it:
  - collects NUIOIN input words into holding registers;
  - releases the processor (proc_run) and serves its one-hot req_in reads;
  - captures the one-hot out_en results;
  - stops the processor and drains the results downstream in port order.
- Includes a timeout watchdog and sticky protocol-error flags.

---
 rtl/taylor_io_pkg.sv | 24 ++
 rtl/onehot_idx.sv | 23 ++
 rtl/taylor_frame_ctrl.sv | 168 ++++++++++++++++
 tb/tb_taylor_frame_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taylor_io_pkg.sv
// Shared state encoding, default widths and port-walk helper for the
// taylor frame sequencer.
package taylor_io_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int NBIN_DEF  = 19;
  localparam int NBOUT_DEF = 28;

  // Lowest index >= start (and < n) whose mask bit is set; returns n when none remains.
  function automatic int next_masked(input logic [31:0] mask, input int start, input int n);
    int r;
    r = n;
    for (int i = 31; i >= 0; i--) begin
      if (i >= start && i < n && mask[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_idx.sv
// Priority encoder for a nominally one-hot strobe vector: lowest set index,
// any-bit-set flag and a multi-hot flag.
module onehot_idx #(
  parameter int  N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_any,
  output logic         o_multi
);

  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = W'(i);
    end
  end

  assign o_any   = |i_vec;
  assign o_multi = |(i_vec & (i_vec - N'(1)));

endmodule

// File: rtl/taylor_frame_ctrl.sv
// Frame sequencer around one proc_fl instance: load inputs, run the processor,
// drain captured results, with a RUN watchdog and sticky protocol-error flags.
//   state | meaning
//   LOAD  | accept NUIOIN upstream samples into holding regs
//   RUN   | processor released; serve req_in reads, capture out_en writes
//   DRAIN | emit masked results downstream in ascending port order
module taylor_frame_ctrl
  import taylor_io_pkg::*;
#(
  parameter int                NBIN     = NBIN_DEF,
  parameter int                NBOUT    = NBOUT_DEF,
  parameter int                NUIOIN   = 4,
  parameter int                NUIOOU   = 4,
  parameter logic [NUIOOU-1:0] OUT_MASK = {NUIOOU{1'b1}},
  parameter int                TMO      = 65535,
  localparam int               IW       = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  localparam int               PW       = (NUIOOU > 1) ? $clog2(NUIOOU) : 1,
  localparam int               TW       = $clog2(TMO + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [NBIN-1:0]   s_data,
  output logic              s_ready,
  input  logic [NUIOIN-1:0] req_in,
  output logic [NBIN-1:0]   io_in,
  input  logic [NUIOOU-1:0] out_en,
  input  logic [NBOUT-1:0]  io_out,
  output logic              proc_run,
  output logic              m_valid,
  output logic [NBOUT-1:0]  m_data,
  output logic [PW-1:0]     m_port,
  input  logic              m_ready,
  output logic [15:0]       frame_cnt,
  output logic              err_tmo,
  output logic              err_proto,
  input  logic              err_clr
);

  localparam int FIRST_PORT = next_masked(32'(OUT_MASK), 0, NUIOOU);

  state_t            r_state;
  logic [IW-1:0]     r_wcnt;
  logic [NBIN-1:0]   r_inreg  [NUIOIN];
  logic [NBOUT-1:0]  r_outreg [NUIOOU];
  logic [NUIOOU-1:0] r_got;
  logic [TW-1:0]     r_tmo_cnt;
  logic [PW-1:0]     r_rcnt;
  logic              r_proc_run;
  logic              r_m_valid;
  logic              r_err_tmo;
  logic              r_err_proto;
  logic [15:0]       r_frame_cnt;

  logic [IW-1:0]     w_req_idx;
  logic              w_req_any;
  logic              w_req_multi;
  logic [PW-1:0]     w_oe_idx;
  logic              w_oe_any;
  logic              w_oe_multi;
  logic              w_cap;
  logic              w_done;
  logic              w_tmo;
  logic              w_proto_evt;
  logic [NUIOOU-1:0] w_new;
  int                w_nxt;

  onehot_idx #(.N(NUIOIN)) u_req_idx (
    .i_vec   (req_in),
    .o_idx   (w_req_idx),
    .o_any   (w_req_any),
    .o_multi (w_req_multi)
  );

  onehot_idx #(.N(NUIOOU)) u_oe_idx (
    .i_vec   (out_en),
    .o_idx   (w_oe_idx),
    .o_any   (w_oe_any),
    .o_multi (w_oe_multi)
  );

  // The strobe that lands this cycle counts toward completion, so done is not delayed a cycle.
  assign w_cap       = (r_state == RUN) && w_oe_any && OUT_MASK[w_oe_idx];
  assign w_new       = w_cap ? (NUIOOU'(1) << w_oe_idx) : '0;
  assign w_done      = (r_state == RUN) && (((r_got | w_new) & OUT_MASK) == OUT_MASK);
  assign w_tmo       = (r_state == RUN) && !w_done && (r_tmo_cnt == TW'(TMO));
  assign w_nxt       = next_masked(32'(OUT_MASK), int'(r_rcnt) + 1, NUIOOU);
  assign w_proto_evt = w_req_multi || w_oe_multi || ((r_state != RUN) && (w_req_any || w_oe_any));

  assign s_ready   = (r_state == LOAD);
  assign io_in     = w_req_any ? r_inreg[w_req_idx] : '0;
  assign proc_run  = r_proc_run;
  assign m_valid   = r_m_valid;
  assign m_data    = r_outreg[r_rcnt];
  assign m_port    = r_rcnt;
  assign frame_cnt = r_frame_cnt;
  assign err_tmo   = r_err_tmo;
  assign err_proto = r_err_proto;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= LOAD;
      r_wcnt      <= '0;
      r_got       <= '0;
      r_tmo_cnt   <= '0;
      r_rcnt      <= '0;
      r_proc_run  <= 1'b0;
      r_m_valid   <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_err_proto <= 1'b0;
      r_frame_cnt <= '0;
      for (int i = 0; i < NUIOIN; i++) r_inreg[i] <= '0;
      for (int i = 0; i < NUIOOU; i++) r_outreg[i] <= '0;
    end else begin
      if (w_proto_evt)  r_err_proto <= 1'b1;
      else if (err_clr) r_err_proto <= 1'b0;
      if (w_tmo)        r_err_tmo <= 1'b1;
      else if (err_clr) r_err_tmo <= 1'b0;

      case (r_state)
        LOAD: begin
          if (s_valid) begin
            r_inreg[r_wcnt] <= s_data;
            if (r_wcnt == IW'(NUIOIN - 1)) begin
              r_wcnt     <= '0;
              r_state    <= RUN;
              r_proc_run <= 1'b1;
              r_tmo_cnt  <= '0;
              r_got      <= '0;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (w_cap) begin
            r_outreg[w_oe_idx] <= io_out;
            r_got              <= r_got | w_new;
          end
          if (w_done) begin
            r_state    <= DRAIN;
            r_proc_run <= 1'b0;
            r_m_valid  <= 1'b1;
            r_rcnt     <= PW'(FIRST_PORT);
          end else if (w_tmo) begin
            r_state    <= LOAD;
            r_proc_run <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (w_nxt >= NUIOOU) begin
              r_state     <= LOAD;
              r_m_valid   <= 1'b0;
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end else begin
              r_rcnt <= PW'(w_nxt);
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_taylor_frame_ctrl.sv
// Self-checking bench for taylor_frame_ctrl: one default instance (A) and one
// with OUT_MASK=4'b0101, TMO=20 (B), selected by 'sel' and driven from shared stimulus.
module tb_taylor_frame_ctrl;

  localparam int B_TMO = 20;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        s_valid;
  logic [18:0] s_data;
  logic [3:0]  req_in;
  logic [3:0]  out_en;
  logic [27:0] io_out;
  logic        m_ready;
  logic        err_clr;

  logic        a_s_valid, b_s_valid, a_err_clr, b_err_clr;
  logic [3:0]  a_req_in, b_req_in, a_out_en, b_out_en;
  logic        a_s_ready, b_s_ready, a_proc_run, b_proc_run, a_m_valid, b_m_valid;
  logic        a_err_tmo, b_err_tmo, a_err_proto, b_err_proto;
  logic [18:0] a_io_in, b_io_in;
  logic [27:0] a_m_data, b_m_data;
  logic [1:0]  a_m_port, b_m_port;
  logic [15:0] a_frame_cnt, b_frame_cnt;

  logic        o_s_ready, o_proc_run, o_m_valid, o_err_tmo, o_err_proto;
  logic [18:0] o_io_in;
  logic [27:0] o_m_data;
  logic [1:0]  o_m_port;
  logic [15:0] o_frame_cnt;

  assign a_s_valid = s_valid && !sel;
  assign b_s_valid = s_valid && sel;
  assign a_req_in  = sel ? 4'b0 : req_in;
  assign b_req_in  = sel ? req_in : 4'b0;
  assign a_out_en  = sel ? 4'b0 : out_en;
  assign b_out_en  = sel ? out_en : 4'b0;
  assign a_err_clr = err_clr && !sel;
  assign b_err_clr = err_clr && sel;

  assign o_s_ready   = sel ? b_s_ready   : a_s_ready;
  assign o_proc_run  = sel ? b_proc_run  : a_proc_run;
  assign o_m_valid   = sel ? b_m_valid   : a_m_valid;
  assign o_err_tmo   = sel ? b_err_tmo   : a_err_tmo;
  assign o_err_proto = sel ? b_err_proto : a_err_proto;
  assign o_io_in     = sel ? b_io_in     : a_io_in;
  assign o_m_data    = sel ? b_m_data    : a_m_data;
  assign o_m_port    = sel ? b_m_port    : a_m_port;
  assign o_frame_cnt = sel ? b_frame_cnt : a_frame_cnt;

  taylor_frame_ctrl u_dut_a (
    .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_data(s_data), .s_ready(a_s_ready),
    .req_in(a_req_in), .io_in(a_io_in), .out_en(a_out_en), .io_out(io_out),
    .proc_run(a_proc_run), .m_valid(a_m_valid), .m_data(a_m_data), .m_port(a_m_port),
    .m_ready(m_ready), .frame_cnt(a_frame_cnt), .err_tmo(a_err_tmo),
    .err_proto(a_err_proto), .err_clr(a_err_clr)
  );

  taylor_frame_ctrl #(.OUT_MASK(4'b0101), .TMO(B_TMO)) u_dut_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_data(s_data), .s_ready(b_s_ready),
    .req_in(b_req_in), .io_in(b_io_in), .out_en(b_out_en), .io_out(io_out),
    .proc_run(b_proc_run), .m_valid(b_m_valid), .m_data(b_m_data), .m_port(b_m_port),
    .m_ready(m_ready), .frame_cnt(b_frame_cnt), .err_tmo(b_err_tmo),
    .err_proto(b_err_proto), .err_clr(b_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_errors;
  int          exp_frames [2];
  logic [18:0] m_in  [4];
  logic [27:0] m_res [4];
  logic [3:0]  m_got;
  int          wr_port [$];
  logic [27:0] wr_data [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_frame();
    m_got = '0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = m_in[i];
      #1;
      chk("load_s_ready", o_s_ready, 1);
      chk("load_proc_run_low", o_proc_run, 0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk("run_s_ready_low", o_s_ready, 0);
    chk("run_proc_run_high", o_proc_run, 1);
  endtask

  task automatic read_req(input int k);
    req_in = 4'(1 << k);
    #1;
    chk("req_io_in", o_io_in, m_in[k]);
    @(posedge clk); #1;
    req_in = 4'b0;
    #1;
    chk("req_idle_io_in", o_io_in, 0);
  endtask

  // Ports written so far decide whether the processor should still be running.
  task automatic run_writes(input logic [3:0] mask);
    for (int i = 0; i < wr_port.size(); i++) begin
      out_en = 4'(1 << wr_port[i]);
      io_out = wr_data[i];
      #1;
      chk("wr_proc_run", o_proc_run, (m_got & mask) != mask);
      chk("wr_m_valid", o_m_valid, (m_got & mask) == mask);
      @(posedge clk); #1;
      if (mask[wr_port[i]]) begin
        m_got[wr_port[i]]  = 1'b1;
        m_res[wr_port[i]] = wr_data[i];
      end
    end
    out_en = 4'b0;
    chk("done_proc_run", o_proc_run, (m_got & mask) != mask);
    chk("done_m_valid", o_m_valid, (m_got & mask) == mask);
  endtask

  task automatic drain(input logic [3:0] mask, input bit rnd);
    int p;
    int guard;
    int idx;
    idx = sel ? 1 : 0;
    p = 0;
    guard = 0;
    while (p < 4 && guard < 200) begin
      if (!mask[p]) begin
        p++;
        continue;
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : guard[0];
      #1;
      chk("drain_m_valid", o_m_valid, 1);
      chk("drain_m_data", o_m_data, m_res[p]);
      chk("drain_m_port", o_m_port, p);
      @(posedge clk); #1;
      if (m_ready) p++;
      guard++;
    end
    m_ready = 1'b0;
    chk("drain_bounded", guard < 200, 1);
    exp_frames[idx]++;
    chk("end_m_valid", o_m_valid, 0);
    chk("end_s_ready", o_s_ready, 1);
    chk("end_frame_cnt", o_frame_cnt, exp_frames[idx]);
  endtask

  // Full random frame on a fully masked instance: one port is rewritten before completion.
  task automatic random_frame();
    int perm [4];
    int j;
    int t;
    for (int i = 0; i < 4; i++) begin
      m_in[i] = 19'($urandom);
      perm[i] = i;
    end
    load_frame();
    repeat (3) read_req(int'($urandom_range(0, 3)));
    for (int i = 3; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    wr_port.delete();
    wr_data.delete();
    wr_port.push_back(perm[0]); wr_data.push_back(28'($urandom));
    wr_port.push_back(perm[1]); wr_data.push_back(28'($urandom));
    wr_port.push_back(perm[0]); wr_data.push_back(28'($urandom));
    wr_port.push_back(perm[2]); wr_data.push_back(28'($urandom));
    wr_port.push_back(perm[3]); wr_data.push_back(28'($urandom));
    run_writes(4'hF);
    drain(4'hF, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "bench watchdog");
  end

  initial begin
    int n;
    logic [27:0] x;
    n_checks = 0;
    n_errors = 0;
    exp_frames[0] = 0;
    exp_frames[1] = 0;
    rst = 1'b1; sel = 1'b0; s_valid = 1'b0; s_data = '0; req_in = '0;
    out_en = '0; io_out = '0; m_ready = 1'b0; err_clr = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_s_ready", o_s_ready, 1);
    chk("rst_proc_run", o_proc_run, 0);
    chk("rst_m_valid", o_m_valid, 0);
    chk("rst_frame_cnt", o_frame_cnt, 0);
    chk("rst_err_tmo", o_err_tmo, 0);
    chk("rst_err_proto", o_err_proto, 0);
    chk("rst_io_in", o_io_in, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed frame on A: samples 10..40, results A..D, toggling m_ready.
    m_in[0] = 19'd10; m_in[1] = 19'd20; m_in[2] = 19'd30; m_in[3] = 19'd40;
    load_frame();
    read_req(2);
    wr_port.delete(); wr_data.delete();
    for (int i = 0; i < 4; i++) begin
      wr_port.push_back(i);
      wr_data.push_back(28'hA0A0A0A + 28'(i * 28'h1111111));
    end
    run_writes(4'hF);
    drain(4'hF, 1'b0);
    chk("dir_no_proto", o_err_proto, 0);

    repeat (5) random_frame();

    // Protocol errors on A.
    for (int i = 0; i < 4; i++) m_in[i] = 19'($urandom);
    load_frame();
    req_in = 4'b0110;
    #1;
    chk("multi_req_io_in", o_io_in, m_in[1]);
    @(posedge clk); #1;
    req_in = 4'b0;
    chk("multi_req_err", o_err_proto, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr_proto", o_err_proto, 0);
    x = 28'($urandom);
    out_en = 4'b0011;
    io_out = x;
    @(posedge clk); #1;
    out_en = 4'b0;
    m_got[0] = 1'b1;
    m_res[0] = x;
    chk("multi_oe_err", o_err_proto, 1);
    chk("multi_oe_running", o_proc_run, 1);
    wr_port.delete(); wr_data.delete();
    for (int i = 1; i < 4; i++) begin
      wr_port.push_back(i);
      wr_data.push_back(28'($urandom));
    end
    run_writes(4'hF);
    drain(4'hF, 1'b1);
    req_in = 4'b0001;
    #1;
    chk("load_req_io_in", o_io_in, m_in[0]);
    @(posedge clk); #1;
    chk("load_req_err", o_err_proto, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_vs_event", o_err_proto, 1);
    req_in = 4'b0;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr_after_event", o_err_proto, 0);
    out_en = 4'b0100;
    @(posedge clk); #1;
    out_en = 4'b0;
    chk("load_oe_err", o_err_proto, 1);
    chk("load_oe_state", o_s_ready, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;

    // Instance B: partial output mask, then watchdog abort.
    sel = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) m_in[i] = 19'($urandom);
    load_frame();
    wr_port.delete(); wr_data.delete();
    for (int i = 0; i < 3; i++) begin
      wr_port.push_back(i);
      wr_data.push_back(28'($urandom));
    end
    run_writes(4'b0101);
    drain(4'b0101, 1'b1);
    chk("b_no_proto", o_err_proto, 0);

    for (int i = 0; i < 4; i++) m_in[i] = 19'($urandom);
    load_frame();
    n = 0;
    while (o_proc_run && n < 100) begin
      chk("tmo_no_m_valid", o_m_valid, 0);
      @(posedge clk); #1;
      n++;
    end
    // Counter runs 0..TMO inclusive before the abort takes effect.
    chk("tmo_run_cycles", n, B_TMO + 1);
    chk("tmo_err_tmo", o_err_tmo, 1);
    chk("tmo_m_valid", o_m_valid, 0);
    chk("tmo_s_ready", o_s_ready, 1);
    chk("tmo_frame_cnt", o_frame_cnt, exp_frames[1]);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("tmo_err_clr", o_err_tmo, 0);

    // Reset in the middle of a drain on A.
    sel = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) m_in[i] = 19'($urandom);
    load_frame();
    wr_port.delete(); wr_data.delete();
    for (int i = 0; i < 4; i++) begin
      wr_port.push_back(i);
      wr_data.push_back(28'($urandom));
    end
    run_writes(4'hF);
    m_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      #1;
      chk("pre_rst_m_port", o_m_port, p);
      chk("pre_rst_m_data", o_m_data, m_res[p]);
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_s_ready", o_s_ready, 1);
    chk("mid_rst_proc_run", o_proc_run, 0);
    chk("mid_rst_m_valid", o_m_valid, 0);
    chk("mid_rst_frame_cnt", o_frame_cnt, 0);
    chk("mid_rst_err_proto", o_err_proto, 0);
    chk("mid_rst_io_in", o_io_in, 0);
    exp_frames[0] = 0;
    exp_frames[1] = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    random_frame();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
